// File: rtl/free_list_ckpt_ctrl_pkg.sv
// Shared constants and helpers for the free-list checkpoint controller.
package free_list_ckpt_ctrl_pkg;

  localparam int unsigned ROB_DEPTH_DEF = 32;
  localparam int unsigned NUM_CKPT_DEF  = 4;
  localparam int unsigned TAG_W_DEF     = $clog2(NUM_CKPT_DEF);

  typedef logic [TAG_W_DEF-1:0] ckpt_tag_t;

  // Forward ring distance from 'from' to 'to' in a power-of-two ring of n slots.
  function automatic int unsigned ring_dist(int unsigned from, int unsigned to, int unsigned n);
    return (to - from) & (n - 1);
  endfunction

endpackage

// File: rtl/free_list_ckpt_ctrl_entry.sv
// One free-list snapshot register: loads a new image or drops committed pregs.
module free_list_ckpt_ctrl_entry #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic [Width-1:0] kick_mask_i,
  output logic [Width-1:0] snap_o
);

  logic [Width-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = load_i ? load_data_i : (snap_q & ~kick_mask_i);
    snap_d[0] = 1'b1;  // x0 is never allocatable
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= Width'(1);
    end else begin
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/free_list_ckpt_ctrl.sv
// Branch checkpoint controller: snapshots the free-list bitmap per in-flight branch
// and supplies the restore image on a mispredict.
module free_list_ckpt_ctrl
  import free_list_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int unsigned NUM_CKPT  = NUM_CKPT_DEF,
  localparam int unsigned NumPreg  = ROB_DEPTH + 32,
  localparam int unsigned PregW    = $clog2(NumPreg),
  localparam int unsigned TagW     = $clog2(NUM_CKPT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NumPreg-1:0]  free_listdata,
  input  logic                dispatch_ren,
  input  logic [PregW-1:0]    free_p_addr,
  input  logic                rrat_kick,
  input  logic [PregW-1:0]    rrat_kick_p_addr,
  input  logic                br_dispatch,
  output logic [TagW-1:0]     alloc_tag,
  output logic                ckpt_full,
  input  logic                br_resolve,
  input  logic [TagW-1:0]     br_resolve_tag,
  input  logic                br_mispred,
  output logic                restore_valid,
  output logic [NumPreg-1:0]  br_free_list,
  output logic [NUM_CKPT-1:0] ckpt_valid
);

  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [TagW-1:0]     tail_q, tail_d;
  logic [NumPreg-1:0]  snap [NUM_CKPT];
  logic [NumPreg-1:0]  kick_mask;
  logic [NumPreg-1:0]  load_data;
  logic                mispred;
  logic                tag_hit;
  logic                alloc;
  int unsigned         span;

  assign mispred = br_resolve && br_mispred;
  assign tag_hit = valid_q[br_resolve_tag];
  assign alloc   = br_dispatch && !ckpt_full && !mispred;

  always_comb begin
    kick_mask = '0;
    if (rrat_kick && (rrat_kick_p_addr != '0)) begin
      kick_mask[rrat_kick_p_addr] = 1'b1;
    end
  end

  // Kick clears after the allocation set, so a same-cycle commit never leaks.
  always_comb begin
    load_data = free_listdata;
    if (dispatch_ren) begin
      load_data[free_p_addr] = 1'b1;
    end
    load_data = load_data & ~kick_mask;
  end

  for (genvar i = 0; i < NUM_CKPT; i++) begin : g_entry
    free_list_ckpt_ctrl_entry #(
      .Width(NumPreg)
    ) u_entry (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (alloc && (tail_q == TagW'(i))),
      .load_data_i(load_data),
      .kick_mask_i(kick_mask),
      .snap_o     (snap[i])
    );
  end

  always_comb begin
    valid_d = valid_q;
    tail_d  = tail_q;
    // tail == tag with the tag valid means the ring is full: squash every slot.
    span    = ring_dist(32'(br_resolve_tag), 32'(tail_q), NUM_CKPT);
    if (span == 0) begin
      span = NUM_CKPT;
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (br_resolve && tag_hit) begin
      if (br_mispred) begin
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
          if (ring_dist(32'(br_resolve_tag), i, NUM_CKPT) < span) begin
            valid_d[i] = 1'b0;
          end
        end
        tail_d = br_resolve_tag;
      end else begin
        valid_d[br_resolve_tag] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tail_q  <= tail_d;
    end
  end

  assign ckpt_full     = valid_q[tail_q];
  assign alloc_tag     = tail_q;
  assign ckpt_valid    = valid_q;
  assign restore_valid = mispred;
  assign br_free_list  = mispred ? (snap[br_resolve_tag] & ~kick_mask) : '0;

endmodule

// File: tb/tb_free_list_ckpt_ctrl.sv
// Directed scoreboard bench for free_list_ckpt_ctrl.
module tb_free_list_ckpt_ctrl;

  localparam int unsigned NP = 64;
  localparam int unsigned PW = 6;
  localparam int unsigned NC = 4;
  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] free_listdata;
  logic          dispatch_ren;
  logic [PW-1:0] free_p_addr;
  logic          rrat_kick;
  logic [PW-1:0] rrat_kick_p_addr;
  logic          br_dispatch;
  logic [TW-1:0] alloc_tag;
  logic          ckpt_full;
  logic          br_resolve;
  logic [TW-1:0] br_resolve_tag;
  logic          br_mispred;
  logic          restore_valid;
  logic [NP-1:0] br_free_list;
  logic [NC-1:0] ckpt_valid;

  always #5 clk = ~clk;

  free_list_ckpt_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .free_listdata   (free_listdata),
    .dispatch_ren    (dispatch_ren),
    .free_p_addr     (free_p_addr),
    .rrat_kick       (rrat_kick),
    .rrat_kick_p_addr(rrat_kick_p_addr),
    .br_dispatch     (br_dispatch),
    .alloc_tag       (alloc_tag),
    .ckpt_full       (ckpt_full),
    .br_resolve      (br_resolve),
    .br_resolve_tag  (br_resolve_tag),
    .br_mispred      (br_mispred),
    .restore_valid   (restore_valid),
    .br_free_list    (br_free_list),
    .ckpt_valid      (ckpt_valid)
  );

  typedef enum int {KValid, KFull, KTag, KRestore} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [63:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] rest_q[$];
  string       rest_name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic expect_out(input string name, input kind_e k, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.kind = k;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_restore(input string name, input logic [63:0] v);
    rest_q.push_back(v);
    rest_name_q.push_back(name);
    expect_out({name, "_rv"}, KRestore, 64'd1);
  endtask

  // Monitor: drains pending expectations and checks every presented restore image.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    string       nm;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        KValid:  act = 64'(ckpt_valid);
        KFull:   act = 64'(ckpt_full);
        KTag:    act = 64'(alloc_tag);
        default: act = 64'(restore_valid);
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
    if (restore_valid !== 1'b0) begin
      n_checks++;
      if (rest_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_restore: got restore_valid=%b image 0x%0h expected none",
                 restore_valid, br_free_list);
      end else begin
        act = rest_q.pop_front();
        nm  = rest_name_q.pop_front();
        if (br_free_list !== act) begin
          n_fail++;
          $display("FAIL %s: got br_free_list 0x%0h expected 0x%0h", nm, br_free_list, act);
        end
      end
    end else begin
      n_checks++;
      if (br_free_list !== '0) begin
        n_fail++;
        $display("FAIL idle_free_list: got 0x%0h expected 0x0", br_free_list);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_dispatch      = 1'b0;
    dispatch_ren     = 1'b0;
    free_p_addr      = '0;
    rrat_kick        = 1'b0;
    rrat_kick_p_addr = '0;
    br_resolve       = 1'b0;
    br_mispred       = 1'b0;
    br_resolve_tag   = '0;
  endtask

  task automatic disp(input logic [63:0] fl, input logic [TW-1:0] tag, input string name);
    idle();
    free_listdata = fl;
    br_dispatch   = 1'b1;
    expect_out(name, KTag, 64'(tag));
    expect_out({name, "_full"}, KFull, 64'd0);
    step();
  endtask

  task automatic mispredict(input logic [TW-1:0] tag, input logic [63:0] img, input string name);
    idle();
    br_resolve     = 1'b1;
    br_mispred     = 1'b1;
    br_resolve_tag = tag;
    expect_restore(name, img);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    free_listdata = '0;
    rst = 1'b1;
    step();
    expect_out("rst_valid", KValid, 64'h0);
    expect_out("rst_full", KFull, 64'd0);
    expect_out("rst_tag", KTag, 64'd0);
    expect_out("rst_rv", KRestore, 64'd0);
    step();
    rst = 1'b0;

    // Fill all slots, then a dispatch while full is ignored.
    for (int i = 0; i < 4; i++) disp(64'h1, TW'(i), $sformatf("fill_tag%0d", i));
    idle();
    br_dispatch = 1'b1;
    expect_out("full_set", KFull, 64'd1);
    expect_out("full_valid", KValid, 64'hF);
    step();
    mispredict(2'd0, 64'h1, "wrap_all_restore");
    expect_out("ignored_valid", KValid, 64'hF);
    expect_out("ignored_tag", KTag, 64'd0);
    step();
    idle();
    expect_out("wrap_all_valid", KValid, 64'h0);
    expect_out("wrap_all_tag", KTag, 64'd0);
    expect_out("wrap_all_full", KFull, 64'd0);

    // Same-cycle allocate and commit kick.
    free_listdata    = 64'h0F;
    br_dispatch      = 1'b1;
    dispatch_ren     = 1'b1;
    free_p_addr      = 6'd5;
    rrat_kick        = 1'b1;
    rrat_kick_p_addr = 6'd2;
    expect_out("akick_tag", KTag, 64'd0);
    step();
    mispredict(2'd0, 64'h2B, "akick_restore");
    step();

    // Kick after snapshot, then restore while kicking again.
    disp(64'h0F, 2'd0, "kafter_tag");
    idle();
    rrat_kick        = 1'b1;
    rrat_kick_p_addr = 6'd3;
    step();
    mispredict(2'd0, 64'h05, "kafter_restore");
    rrat_kick        = 1'b1;
    rrat_kick_p_addr = 6'd1;
    expect_out("kafter_valid", KValid, 64'h1);
    step();

    // Nested mispredict with squashed concurrent dispatch.
    disp(64'h11, 2'd0, "nest_t0");
    disp(64'h21, 2'd1, "nest_t1");
    disp(64'h41, 2'd2, "nest_t2");
    mispredict(2'd1, 64'h21, "nest_restore");
    br_dispatch   = 1'b1;
    free_listdata = 64'hF1;
    expect_out("nest_pre_valid", KValid, 64'h7);
    step();
    idle();
    expect_out("nest_valid", KValid, 64'h1);
    expect_out("nest_tag", KTag, 64'd1);

    // Out-of-order correct resolves.
    disp(64'h101, 2'd1, "ooo_t1");
    disp(64'h201, 2'd2, "ooo_t2");
    disp(64'h801, 2'd3, "ooo_t3");
    idle();
    br_resolve     = 1'b1;
    br_resolve_tag = 2'd2;
    expect_out("ooo_full_pre", KFull, 64'd1);
    step();
    idle();
    br_resolve     = 1'b1;
    br_resolve_tag = 2'd0;
    expect_out("ooo_valid_hole", KValid, 64'hB);
    expect_out("ooo_full_hole", KFull, 64'd1);
    step();
    idle();
    expect_out("ooo_full_clear", KFull, 64'd0);
    expect_out("ooo_tag", KTag, 64'd0);
    expect_out("ooo_valid", KValid, 64'hA);

    // Mispredicts that wrap around the ring and skip holes.
    mispredict(2'd3, 64'h801, "wrap_t3_restore");
    step();
    idle();
    expect_out("wrap_t3_valid", KValid, 64'h2);
    expect_out("wrap_t3_tag", KTag, 64'd3);
    mispredict(2'd1, 64'h101, "t1_restore");
    step();
    idle();
    expect_out("t1_valid", KValid, 64'h0);
    expect_out("t1_tag", KTag, 64'd1);

    // Reset mid-operation discards checkpoints.
    disp(64'h3, 2'd1, "mid_tag");
    idle();
    expect_out("mid_valid", KValid, 64'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("mid_rst_valid", KValid, 64'h0);
    expect_out("mid_rst_tag", KTag, 64'd0);
    expect_out("mid_rst_full", KFull, 64'd0);
    step();
    step();

    n_checks++;
    if (exp_q.size() != 0 || rest_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0",
               exp_q.size(), rest_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list_ckpt_ctrl.md
# free_list_ckpt_ctrl

Branch-checkpoint controller for the physical-register free list. It snapshots the free-list bitmap whenever a branch or jump is dispatched and tracks each snapshot by a checkpoint tag. On a misprediction it supplies the restore image (`br_free_list`) and releases the mispredicted checkpoint and every younger one. It sits between dispatch/rename, the CDB branch-resolution path, the RRAT commit path and the free list.

## Interface
- `ROB_DEPTH`, 32, ROB entries; physical registers = ROB_DEPTH+32, `PREG_W` = $clog2(ROB_DEPTH+32)
- `NUM_CKPT`, 4, checkpoint slots; power of two, ≥2; `TAG_W` = $clog2(NUM_CKPT)

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `free_listdata` in ROB_DEPTH+32: current free-list bitmap (1 = busy)
- `dispatch_ren` in 1: a preg is allocated this cycle
- `free_p_addr` in PREG_W: preg being allocated
- `rrat_kick` in 1: commit frees a preg this cycle
- `rrat_kick_p_addr` in PREG_W: preg being freed
- `br_dispatch` in 1: branch/JAL/JALR dispatched this cycle
- `alloc_tag` out TAG_W: tag assigned to the dispatching branch (valid when `br_dispatch` && !`ckpt_full`)
- `ckpt_full` out 1: no free slot; dispatch must stall branches
- `br_resolve` in 1: a branch resolved on CDB
- `br_resolve_tag` in TAG_W: its tag
- `br_mispred` in 1: the resolving branch mispredicted
- `restore_valid` out 1: mispredict restore this cycle
- `br_free_list` out ROB_DEPTH+32: restore image
- `ckpt_valid` out NUM_CKPT: occupied slots

## Operation
- Slots are allocated in ring order at pointer `tail`. `ckpt_full` = `ckpt_valid[tail]` (registered state only).
- Allocate (`br_dispatch` && !`ckpt_full` && !(`br_resolve` && `br_mispred`)):
  - snapshot[tail] <= `free_listdata`, with bit `free_p_addr` set if `dispatch_ren`, and bit `rrat_kick_p_addr` cleared if `rrat_kick` and addr ≠ 0;
  - set valid[tail]; `tail` <= tail+1 mod NUM_CKPT; `alloc_tag` = tail.
- `br_dispatch` while `ckpt_full` is ignored. This is an assertion error.
- Commit tracking: on `rrat_kick` with addr ≠ 0, clear that bit in every valid snapshot the same edge. Committed instructions are older than all in-flight branches, so this prevents leaks on restore.
- Correct resolve (`br_resolve` && !`br_mispred`): clear valid[`br_resolve_tag`]. Slots may free out of order, leaving holes; `tail` is unchanged.
- Mispredict (`br_resolve` && `br_mispred`):
  - `restore_valid` = 1;
  - `br_free_list` = snapshot[`br_resolve_tag`], with the same-cycle `rrat_kick` bit cleared. The free list ignores the kick on a restore cycle.
  - Clear valid for `br_resolve_tag` and every slot in ring order from tag+1 up to tail−1; `tail` <= `br_resolve_tag`.
  - Same-cycle `br_dispatch` is squashed: no allocation.
- `br_free_list` = '0 when `restore_valid` is low.
- A resolve with an invalid tag is an assertion error; state is unchanged.
- Bit 0 (x0) is always 1 in every snapshot.

## Timing
- Reset values: valid = '0, `tail` = 0, snapshots = {'0, bit0=1}, `ckpt_full` = 0, `restore_valid` = 0, `br_free_list` = '0, `alloc_tag` = 0.
- `alloc_tag`, `ckpt_full`, `restore_valid` and `br_free_list` are combinational; there is zero-latency restore in the mispredict cycle.
- Snapshots, valid bits and `tail` update at the next posedge.
- A slot freed by a correct resolve in cycle N is allocatable in cycle N+1. `ckpt_full` is not bypassed.
- `rst` asserted mid-operation discards all checkpoints on the next edge.

## Structure
- `rv32i_types` additions: `NUM_CKPT` constant and `ckpt_tag_t` (logic [TAG_W-1:0]). Add a `ckpt_tag_t` field to the CDB packet when the ROB integration is done.
- Optional sub-module `fl_ckpt_entry`: one snapshot register with load / kick-clear ports, instantiated NUM_CKPT times.

## Test plan
- **Reset, no branches:** `ckpt_full`=0, `ckpt_valid`=0, `restore_valid`=0, `br_free_list`=0.
- **Fill:** dispatch 4 branches with `free_listdata`=0x1 → tags 0,1,2,3 then `ckpt_full`=1. A 5th dispatch is ignored and `ckpt_valid` stays 4'hF.
- **Same-cycle alloc and kick:** `free_listdata`=0x0F, `dispatch_ren`, `free_p_addr`=5, `rrat_kick` addr 2 → snapshot = 0x2B. Mispredict on that tag gives `br_free_list`=0x2B.
- **Kick after snapshot:** snapshot 0x0F on tag 0; kick addr 3 one cycle later; then mispredict tag 0 while kicking addr 1 → `br_free_list`=0x05.
- **Nested mispredict:** tags 0,1,2 valid; mispredict tag 1 → `ckpt_valid`=4'b0001, next `alloc_tag`=1. Concurrent `br_dispatch` allocates nothing.
- **Out-of-order correct resolve:** with all 4 slots full, resolve tag 2 correct → `ckpt_valid`=4'b1011 and `ckpt_full` stays 1 (`tail`=0 still busy). Resolve tag 0 → next cycle `ckpt_full`=0, `alloc_tag`=0.
